// File: rtl/lcd_cmd_sched_if.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sched_if
// Host-side command handshake of the LCD command scheduler.
//   host_cmd    3       command code (0 REFLASH .. 5 DOWN, 6/7 illegal)
//   host_bank   BANK_W  image bank used by LOAD_DATA
//   host_valid  1       push request
//   host_ready  1       scheduler can accept a push this cycle
//   cmd_err     1       one-cycle pulse after an illegal code was offered
// master = host side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface lcd_cmd_sched_if #(
   parameter int BANK_W = 2
);
   logic [2:0]        host_cmd;
   logic [BANK_W-1:0] host_bank;
   logic              host_valid;
   logic              host_ready;
   logic              cmd_err;

   modport master (
      output host_cmd, host_bank, host_valid,
      input  host_ready, cmd_err
   );

   modport slave (
      input  host_cmd, host_bank, host_valid,
      output host_ready, cmd_err
   );
endinterface

// File: rtl/lcd_cmd_sched.sv
// ---------------------------------------------------------------------------
// lcd_cmd_sched
// Queues host commands in a small FIFO and issues them one at a time to
// lcd_ctrl. LOAD_DATA streams 36 bytes from a synchronous image memory into
// lcd_ctrl, then the scheduler waits for the 9-beat refresh to finish.
// Ports:
//   clk, reset        clock (rising edge), asynchronous active-low reset
//   host              host command handshake (lcd_cmd_sched_if.slave)
//   imem_addr/imem_rd image memory read port; imem_q returns one cycle later
//   imem_q            image memory read data
//   lcd_cmd/_valid    command to lcd_ctrl, valid for one cycle per command
//   lcd_datain        image byte to lcd_ctrl (combinational copy of imem_q)
//   lcd_busy          lcd_ctrl busy; low again on the last output beat
//   lcd_ovalid        lcd_ctrl output beat strobe
//   frame_done        one-cycle pulse after a refresh completes
//   beat_cnt          output beats seen for the current command (0..9)
//   err_timeout       sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module lcd_cmd_sched #(
   parameter int DEPTH  = 4,
   parameter int BANK_W = 2,
   parameter int WDOG   = 64
) (
   input  logic              clk,
   input  logic              reset,
   lcd_cmd_sched_if.slave    host,
   output logic [BANK_W+5:0] imem_addr,
   output logic              imem_rd,
   input  logic [7:0]        imem_q,
   output logic [2:0]        lcd_cmd,
   output logic              lcd_cmd_valid,
   output logic [7:0]        lcd_datain,
   input  logic              lcd_busy,
   input  logic              lcd_ovalid,
   output logic              frame_done,
   output logic [3:0]        beat_cnt,
   output logic              err_timeout
);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = $clog2(WDOG + 1);
   localparam int EW = BANK_W + 3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_WAIT  = 2'd3;

   localparam logic [2:0] CMD_LOAD = 3'd1;
   localparam logic [5:0] LAST_OFS = 6'd35;

   logic [EW-1:0]     fifo_mem [DEPTH];
   logic [AW:0]       wr_ptr, rd_ptr;
   logic              full, empty;
   logic              ready_en;
   logic              cmd_err_q;
   logic              push, bad_push, pop;
   logic [1:0]        state;
   logic [5:0]        ofs;
   logic [WW-1:0]     wd;
   logic [2:0]        cur_cmd;
   logic [BANK_W-1:0] cur_bank;

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // ready_en keeps host_ready low during reset and for the first cycle after it.
   assign host.host_ready = ready_en & ~full;
   assign host.cmd_err    = cmd_err_q;

   assign push     = host.host_valid & host.host_ready & (host.host_cmd <= 3'd5);
   assign bad_push = host.host_valid & host.host_ready & (host.host_cmd > 3'd5);
   assign pop      = (state == S_IDLE) & ~empty & ~lcd_busy;

   assign lcd_cmd       = cur_cmd;
   assign lcd_cmd_valid = (state == S_ISSUE);
   assign imem_rd       = (state == S_ISSUE) || (state == S_LOAD);
   assign imem_addr     = imem_rd ? {cur_bank, ofs} : '0;
   assign lcd_datain    = reset ? imem_q : 8'd0;

   // FIFO storage needs no reset; validity is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr[AW-1:0]] <= {host.host_cmd, host.host_bank};
      end
   end

   // FIFO pointers, ready enable and the illegal-command pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         ready_en  <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         ready_en  <= 1'b1;
         cmd_err_q <= bad_push;
         if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
   end

   // Issue FSM. The watchdog starts at 0 in the ISSUE cycle and counts every
   // cycle of the command; the timeout only fires while waiting for busy to fall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         ofs         <= '0;
         wd          <= '0;
         cur_cmd     <= '0;
         cur_bank    <= '0;
         beat_cnt    <= '0;
         frame_done  <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  {cur_cmd, cur_bank} <= fifo_mem[rd_ptr[AW-1:0]];
                  beat_cnt <= '0;
                  wd       <= '0;
                  ofs      <= '0;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               wd <= wd + WW'(1);
               if (cur_cmd == CMD_LOAD) begin
                  ofs   <= 6'd1;
                  state <= S_LOAD;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_LOAD: begin
               wd <= wd + WW'(1);
               if (ofs == LAST_OFS) state <= S_WAIT;
               else                 ofs   <= ofs + 6'd1;
            end
            default: begin
               wd <= wd + WW'(1);
               if (lcd_ovalid && (beat_cnt < 4'd9)) beat_cnt <= beat_cnt + 4'd1;
               if (!lcd_busy) begin
                  frame_done <= 1'b1;
                  state      <= S_IDLE;
               end else if (wd >= WW'(WDOG - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= S_IDLE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lcd_cmd_sched.sv
// ---------------------------------------------------------------------------
// tb_lcd_cmd_sched
// Bench for lcd_cmd_sched: an image memory, a behavioural lcd_ctrl, a
// reference model of the expected commands and refresh frames, and a monitor
// that pops the expectations whenever the design issues or completes.
// ---------------------------------------------------------------------------
module tb_lcd_cmd_sched;
   localparam int DEPTH  = 4;
   localparam int BANK_W = 2;
   localparam int WDOG   = 64;

   logic              clk   = 1'b0;
   logic              reset = 1'b0;
   logic [BANK_W+5:0] imem_addr;
   logic              imem_rd;
   logic [7:0]        imem_q = 8'd0;
   logic [2:0]        lcd_cmd;
   logic              lcd_cmd_valid;
   logic [7:0]        lcd_datain;
   logic              lcd_busy;
   logic              lcd_ovalid;
   logic              frame_done;
   logic [3:0]        beat_cnt;
   logic              err_timeout;

   lcd_cmd_sched_if #(.BANK_W(BANK_W)) hif ();

   lcd_cmd_sched #(.DEPTH(DEPTH), .BANK_W(BANK_W), .WDOG(WDOG)) dut (
      .clk          (clk),
      .reset        (reset),
      .host         (hif),
      .imem_addr    (imem_addr),
      .imem_rd      (imem_rd),
      .imem_q       (imem_q),
      .lcd_cmd      (lcd_cmd),
      .lcd_cmd_valid(lcd_cmd_valid),
      .lcd_datain   (lcd_datain),
      .lcd_busy     (lcd_busy),
      .lcd_ovalid   (lcd_ovalid),
      .frame_done   (frame_done),
      .beat_cnt     (beat_cnt),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Synchronous image memory: data one cycle after the read strobe.
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (imem_rd) imem_q <= mem[imem_addr];
   end

   // Behavioural lcd_ctrl: accepts a command while idle, stores 36 bytes for
   // LOAD_DATA, then emits 9 window beats with busy low on the last beat.
   logic       mbusy = 1'b0, mload = 1'b0, stuck = 1'b0;
   int         mcnt = 0, mr = 2, mc = 2, mbase, bi;
   logic [7:0] lbuf [36];
   logic [7:0] mbeat;

   always_comb begin
      bi         = 0;
      mbeat      = 8'd0;
      mbase      = mload ? 36 : 3;
      lcd_ovalid = !stuck && mbusy && (mcnt > mbase) && (mcnt <= mbase + 9);
      lcd_busy   = stuck || (mbusy && (mcnt != mbase + 9));
      if (lcd_ovalid) begin
         bi    = mcnt - mbase - 1;
         mbeat = lbuf[(mr + bi / 3) * 6 + mc + bi % 3];
      end
   end

   // Command acceptance, window moves and beat sequencing of the lcd model.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mbusy <= 1'b0; mcnt <= 0; mload <= 1'b0; mr <= 2; mc <= 2;
      end else if (stuck) begin
         mbusy <= 1'b0; mcnt <= 0;
      end else if (!mbusy) begin
         if (lcd_cmd_valid) begin
            mbusy <= 1'b1;
            mcnt  <= 1;
            mload <= (lcd_cmd == 3'd1);
            case (lcd_cmd)
               3'd1: begin mr <= 2; mc <= 2; end
               3'd2: mc <= (mc < 3) ? mc + 1 : 3;
               3'd3: mc <= (mc > 0) ? mc - 1 : 0;
               3'd4: mr <= (mr > 0) ? mr - 1 : 0;
               3'd5: mr <= (mr < 3) ? mr + 1 : 3;
               default: ;
            endcase
         end
      end else begin
         mcnt <= mcnt + 1;
         if (mcnt == mbase + 9) mbusy <= 1'b0;
      end
   end

   // Byte k sits on lcd_datain in the (k+1)th cycle after the accepting edge.
   always @(posedge clk) begin
      if (reset && !stuck && mbusy && mload && mcnt >= 1 && mcnt <= 36)
         lbuf[mcnt-1] <= lcd_datain;
   end

   // Reference model: image, window origin, expected commands and frames.
   logic [7:0]  ref_img [36];
   int          ref_r = 2, ref_c = 2;
   logic [2:0]  exp_cmds[$];
   logic [71:0] exp_frames[$];
   int          frames_seen = 0, err_pulses = 0, bad_pushes = 0;
   logic [71:0] beat_acc = '0, last_frame = '0;
   int          beat_n = 0;

   function automatic logic [71:0] frameOf();
      logic [71:0] f = '0;
      for (int i = 0; i < 9; i++)
         f = {f[63:0], ref_img[(ref_r + i / 3) * 6 + ref_c + i % 3]};
      return f;
   endfunction

   function automatic void refPush(input int cmd, input int bank, input bit drop);
      case (cmd)
         1: begin
            for (int k = 0; k < 36; k++) ref_img[k] = mem[bank * 64 + k];
            ref_r = 2; ref_c = 2;
         end
         2: ref_c = (ref_c < 3) ? ref_c + 1 : 3;
         3: ref_c = (ref_c > 0) ? ref_c - 1 : 0;
         4: ref_r = (ref_r > 0) ? ref_r - 1 : 0;
         5: ref_r = (ref_r < 3) ? ref_r + 1 : 3;
         default: ;
      endcase
      exp_cmds.push_back(3'(cmd));
      if (!drop) exp_frames.push_back(frameOf());
   endfunction

   task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name, input string what);
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: %s", name, what);
   endtask

   // Monitor: checks every issued command and every completed frame against
   // the reference queues, independently of the stimulus.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            beat_acc = '0;
            beat_n   = 0;
         end else begin
            if (lcd_cmd_valid) begin
               checkOutput("cmd_while_busy", 72'(lcd_busy), 72'd0);
               if (exp_cmds.size() == 0) failNow("unexpected_cmd", $sformatf("got cmd %0d, expected none", lcd_cmd));
               else checkOutput("cmd_order", 72'(lcd_cmd), 72'(exp_cmds.pop_front()));
            end
            if (lcd_ovalid) begin
               beat_acc = {beat_acc[63:0], mbeat};
               beat_n++;
            end
            if (frame_done) begin
               frames_seen++;
               checkOutput("beat_cnt", 72'(beat_cnt), 72'd9);
               checkOutput("beats_seen", 72'(beat_n), 72'd9);
               if (exp_frames.size() == 0) failNow("unexpected_frame", $sformatf("got %0h, expected none", beat_acc));
               else checkOutput("frame_data", beat_acc, exp_frames.pop_front());
               last_frame = beat_acc;
               beat_acc   = '0;
               beat_n     = 0;
            end
            if (hif.cmd_err) err_pulses++;
         end
      end
   end

   // Offers one command at a negedge once host_ready is seen, records the
   // expectation, and returns at the following negedge.
   task automatic applyStimulus(input int cmd, input int bank, input bit drop);
      int t = 0;
      while (!hif.host_ready && t < 4000) begin @(negedge clk); t++; end
      if (!hif.host_ready) begin
         failNow("push_timeout", "got host_ready 0, expected 1");
         return;
      end
      hif.host_cmd   = 3'(cmd);
      hif.host_bank  = BANK_W'(bank);
      hif.host_valid = 1'b1;
      if (cmd <= 5) refPush(cmd, bank, drop);
      else bad_pushes++;
      @(negedge clk);
      hif.host_valid = 1'b0;
      if (cmd > 5) checkOutput("cmd_err_pulse", 72'(hif.cmd_err), 72'd1);
   endtask

   task automatic waitDrained();
      int t = 0;
      while ((exp_cmds.size() != 0 || exp_frames.size() != 0 || lcd_busy) && t < 3000) begin
         @(negedge clk); t++;
      end
      if (t >= 3000) begin
         failNow("drain_timeout", $sformatf("got %0d cmds/%0d frames pending, expected 0", exp_cmds.size(), exp_frames.size()));
         exp_cmds.delete();
         exp_frames.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   int  t, n, issued, fs0, err0;
   logic ok;

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      for (int k = 0; k < 36; k++)   mem[64 + k] = 8'(k + 16);
      hif.host_valid = 1'b0;
      hif.host_cmd   = 3'd0;
      hif.host_bank  = '0;

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("rst_host_ready", 72'(hif.host_ready), 72'd0);
      checkOutput("rst_cmd_valid", 72'(lcd_cmd_valid), 72'd0);
      checkOutput("rst_imem_rd", 72'(imem_rd), 72'd0);
      checkOutput("rst_beat_cnt", 72'(beat_cnt), 72'd0);
      checkOutput("rst_err_timeout", 72'(err_timeout), 72'd0);
      reset = 1'b1;
      checkOutput("ready_at_release", 72'(hif.host_ready), 72'd0);
      @(negedge clk);
      checkOutput("ready_after_release", 72'(hif.host_ready), 72'd1);

      // 1: LOAD bank 1, two-cycle issue latency, known image and frame.
      applyStimulus(1, 1, 1'b0);
      checkOutput("t1_no_early_issue", 72'(lcd_cmd_valid), 72'd0);
      @(negedge clk);
      checkOutput("t1_issue_latency", 72'(lcd_cmd_valid), 72'd1);
      waitDrained();
      checkOutput("t1_frame", last_frame, 72'h1e1f20_242526_2a2b2c);
      ok = 1'b1;
      for (int k = 0; k < 36; k++) if (lbuf[k] !== 8'(k + 16)) ok = 1'b0;
      checkOutput("t1_image_buf", 72'(ok), 72'd1);
      checkOutput("t1_beat_cnt_hold", 72'(beat_cnt), 72'd9);

      // 2: fill the FIFO behind a running UP.
      applyStimulus(4, 0, 1'b0);
      t = 0;
      while (!lcd_busy && t < 50) begin @(negedge clk); t++; end
      applyStimulus(1, 1, 1'b0);
      applyStimulus(2, 0, 1'b0);
      applyStimulus(2, 0, 1'b0);
      applyStimulus(5, 0, 1'b0);
      checkOutput("t2_full_ready", 72'(hif.host_ready), 72'd0);
      waitDrained();
      checkOutput("t2_first_beat", 72'(last_frame[71:64]), 72'h25);

      // 3: LEFT clamps at column 0.
      fs0 = frames_seen;
      applyStimulus(1, 1, 1'b0);
      repeat (3) applyStimulus(3, 0, 1'b0);
      waitDrained();
      checkOutput("t3_frames", 72'(frames_seen - fs0), 72'd4);
      checkOutput("t3_first_beat", 72'(last_frame[71:64]), 72'h1c);

      // 4: illegal code is rejected, UP still runs.
      err0 = err_pulses;
      applyStimulus(7, 0, 1'b0);
      applyStimulus(4, 0, 1'b0);
      waitDrained();
      checkOutput("t4_err_pulses", 72'(err_pulses - err0), 72'd1);

      // Randomized traffic including illegal codes and idle gaps.
      repeat (24) begin
         applyStimulus($urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(negedge clk);
      end
      waitDrained();
      checkOutput("rand_err_pulses", 72'(err_pulses), 72'(bad_pushes));

      // 5: lcd_ctrl hangs after accepting RIGHT; UP waits behind it.
      applyStimulus(2, 0, 1'b1);
      applyStimulus(4, 0, 1'b0);
      t = 0;
      while (!lcd_cmd_valid && t < 50) begin @(negedge clk); t++; end
      n = 0;
      @(negedge clk);
      stuck = 1'b1;
      n = 1;
      while (!err_timeout && n < 200) begin @(negedge clk); n++; end
      checkOutput("t5_timeout_cycle", 72'(n), 72'(WDOG));
      issued = 0;
      repeat (20) begin @(negedge clk); if (lcd_cmd_valid) issued++; end
      checkOutput("t5_no_issue_while_busy", 72'(issued), 72'd0);
      stuck = 1'b0;
      waitDrained();
      checkOutput("t5_err_sticky", 72'(err_timeout), 72'd1);

      // 6: reset in the middle of streaming.
      applyStimulus(1, 3, 1'b0);
      t = 0;
      while (!(imem_rd && imem_addr[5:0] == 6'd20) && t < 50) begin @(negedge clk); t++; end
      checkOutput("t6_reached_k20", 72'(imem_addr[5:0]), 72'd20);
      reset = 1'b0;
      #1;
      checkOutput("t6_host_ready", 72'(hif.host_ready), 72'd0);
      checkOutput("t6_cmd_err", 72'(hif.cmd_err), 72'd0);
      checkOutput("t6_imem", 72'({imem_rd, imem_addr}), 72'd0);
      checkOutput("t6_lcd_cmd", 72'({lcd_cmd_valid, lcd_cmd, lcd_datain}), 72'd0);
      checkOutput("t6_status", 72'({frame_done, beat_cnt, err_timeout}), 72'd0);
      exp_cmds.delete();
      exp_frames.delete();
      ref_r = 2;
      ref_c = 2;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("t6_ready_after_reset", 72'(hif.host_ready), 72'd1);
      issued = 0;
      repeat (5) begin @(negedge clk); if (lcd_cmd_valid) issued++; end
      checkOutput("t6_fifo_empty", 72'(issued), 72'd0);
      fs0 = frames_seen;
      applyStimulus(1, 2, 1'b0);
      waitDrained();
      checkOutput("t6_reload_frames", 72'(frames_seen - fs0), 72'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
